// File: rtl/k12a_inst_queue.sv
// rtl/k12a_inst_queue.sv - byte-serial instruction assembler feeding a circular queue of complete instructions
// Optional same-cycle bypass when empty: define K12A_INST_QUEUE_BYPASS_EN.
module k12a_inst_queue #(
    parameter int INST_BYTES = 2,
    parameter int DEPTH      = 2,
    localparam int IW        = 8 * INST_BYTES,
    localparam int IDXW      = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1,
    localparam int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic            cpu_clock,
    input  logic            reset_n,
    input  logic [7:0]      i_data_bus,
    input  logic            i_byte_store,
    output logic            o_byte_ready,
    output logic [IDXW-1:0] o_byte_index,
    input  logic            i_flush,
    output logic [IW-1:0]   o_inst,
    output logic            o_inst_valid,
    input  logic            i_inst_ack,
    output logic [CNTW-1:0] o_count,
    output logic            o_overflow
);

    localparam int PW   = (INST_BYTES > 1) ? INST_BYTES - 1 : 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(INST_BYTES - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);

    logic [IW-1:0]   r_slot [DEPTH];
    logic [8*PW-1:0] r_partial;
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [CNTW-1:0] r_count;
    logic [IDXW-1:0] r_index;
    logic            r_overflow;

    logic [IW-1:0]   w_full_inst;
    logic            w_ready;
    logic            w_accept;
    logic            w_complete;
    logic            w_nonempty;
    logic            w_bypass;
    logic            w_pop;
    logic            w_push;

    function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTRW'(1);
    endfunction

    generate
        if (INST_BYTES == 1) begin : g_single
            assign w_full_inst = i_data_bus;
        end else begin : g_multi
            assign w_full_inst = {r_partial, i_data_bus};
        end
    endgenerate

    assign w_ready    = (r_count != FULL_CNT);
    assign w_accept   = i_byte_store & w_ready & ~i_flush;
    assign w_complete = w_accept & (r_index == LAST_IDX);
    assign w_nonempty = (r_count != '0);

`ifdef K12A_INST_QUEUE_BYPASS_EN
    assign w_bypass = w_complete & ~w_nonempty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction that is acked in the same cycle never occupies a slot.
    assign w_pop  = i_inst_ack & w_nonempty & ~i_flush;
    assign w_push = w_complete & ~(w_bypass & i_inst_ack);

    assign o_byte_ready = w_ready;
    assign o_byte_index = r_index;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_inst_valid = w_nonempty | w_bypass;
    assign o_inst       = w_nonempty ? r_slot[r_head] : (w_bypass ? w_full_inst : '0);

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_byte_store && !w_ready) begin
                r_overflow <= 1'b1;
            end
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_index <= '0;
            end else begin
                if (w_accept) begin
                    r_index <= w_complete ? '0 : r_index + IDXW'(1);
                end
                if (w_push) begin
                    r_tail <= next_ptr(r_tail);
                end
                if (w_pop) begin
                    r_head <= next_ptr(r_head);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNTW'(1);
                    2'b01:   r_count <= r_count - CNTW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Data storage needs no reset: stale contents are masked by count and index.
    always_ff @(posedge cpu_clock) begin
        if (w_accept && !w_complete) begin
            r_partial[8*(PW-1-int'(r_index)) +: 8] <= i_data_bus;
        end
        if (w_push) begin
            r_slot[r_tail] <= w_full_inst;
        end
    end

endmodule

// File: tb/tb_k12a_inst_queue.sv
// tb/tb_k12a_inst_queue.sv - directed and randomized checks of k12a_inst_queue against a queue-based model
module tb_k12a_inst_queue;

    localparam int IB    = 2;
    localparam int DEPTH = 2;

    logic        cpu_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  i_data_bus = 8'h00;
    logic        i_byte_store = 1'b0;
    logic        o_byte_ready;
    logic [0:0]  o_byte_index;
    logic        i_flush = 1'b0;
    logic [15:0] o_inst;
    logic        o_inst_valid;
    logic        i_inst_ack = 1'b0;
    logic [1:0]  o_count;
    logic        o_overflow;

    k12a_inst_queue #(.INST_BYTES(IB), .DEPTH(DEPTH)) dut (
        .cpu_clock   (cpu_clock),
        .reset_n     (reset_n),
        .i_data_bus  (i_data_bus),
        .i_byte_store(i_byte_store),
        .o_byte_ready(o_byte_ready),
        .o_byte_index(o_byte_index),
        .i_flush     (i_flush),
        .o_inst      (o_inst),
        .o_inst_valid(o_inst_valid),
        .i_inst_ack  (i_inst_ack),
        .o_count     (o_count),
        .o_overflow  (o_overflow)
    );

    always #5 cpu_clock = ~cpu_clock;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: list of finished instructions, assembly bytes, next byte position.
    logic [15:0] mq[$];
    logic [7:0]  m_part;
    int          m_idx;
    logic        m_ovf;

`ifdef K12A_INST_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    function automatic bit model_bypass();
        return BYPASS && mq.size() == 0 && i_byte_store && !i_flush && m_idx == IB - 1;
    endfunction

    task automatic compare(input string pfx);
        logic [15:0] exp_inst;
        bit          byp;
        byp = model_bypass();
        exp_inst = (mq.size() != 0) ? mq[0] : (byp ? {m_part, i_data_bus} : 16'h0);
        check({pfx, "_inst"},  32'(o_inst), 32'(exp_inst));
        check({pfx, "_valid"}, 32'(o_inst_valid), 32'(mq.size() != 0 || byp));
        check({pfx, "_count"}, 32'(o_count), 32'(mq.size()));
        check({pfx, "_index"}, 32'(o_byte_index), 32'(m_idx));
        check({pfx, "_ready"}, 32'(o_byte_ready), 32'(mq.size() != DEPTH));
        check({pfx, "_ovf"},   32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic model_update();
        bit ready;
        bit byp;
        bit had;
        ready = (mq.size() != DEPTH);
        byp   = model_bypass();
        had   = (mq.size() != 0);
        if (i_byte_store && !ready) m_ovf = 1'b1;
        if (i_flush) begin
            mq.delete();
            m_idx = 0;
        end else begin
            if (i_inst_ack && had) void'(mq.pop_front());
            if (i_byte_store && ready) begin
                if (m_idx < IB - 1) begin
                    m_part = i_data_bus;
                    m_idx++;
                end else begin
                    if (!(byp && i_inst_ack)) mq.push_back({m_part, i_data_bus});
                    m_idx = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit s, input logic [7:0] d, input bit a, input bit f);
        i_byte_store = s;
        i_data_bus   = d;
        i_inst_ack   = a;
        i_flush      = f;
        #1;
    endtask

    task automatic clock_update();
        @(posedge cpu_clock);
        model_update();
        #1;
    endtask

    task automatic step(input bit s, input logic [7:0] d, input bit a, input bit f);
        drive(s, d, a, f);
        compare("cyc");
        clock_update();
    endtask

    task automatic async_reset();
        drive(0, 8'h00, 0, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare("rst");
        check("rst_inst", 32'(o_inst), 32'h0);
        check("rst_ready", 32'(o_byte_ready), 32'h1);
        check("rst_ovf", 32'(o_overflow), 32'h0);
        @(negedge cpu_clock);
        reset_n = 1'b1;
        @(posedge cpu_clock);
        #1;
    endtask

    initial begin
        model_reset();
        m_part = 8'h00;
        #2;
        compare("init");
        @(negedge cpu_clock);
        reset_n = 1'b1;
        @(posedge cpu_clock);
        #1;

        // Two-byte assembly, MSB first.
        step(1, 8'h12, 0, 0);
        check("t1_index_mid", 32'(o_byte_index), 32'h1);
        step(1, 8'h34, 0, 0);
        check("t1_inst", 32'(o_inst), 32'h1234);
        check("t1_valid", 32'(o_inst_valid), 32'h1);
        check("t1_count", 32'(o_count), 32'h1);
        check("t1_index", 32'(o_byte_index), 32'h0);
        step(0, 8'h00, 1, 0);

        // Fill, then a rejected store.
        step(1, 8'hAA, 0, 0); step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0); step(1, 8'hBB, 0, 0);
        check("t2_ready_full", 32'(o_byte_ready), 32'h0);
        step(1, 8'hCC, 0, 0);
        check("t2_ovf", 32'(o_overflow), 32'h1);
        check("t2_index", 32'(o_byte_index), 32'h0);
        check("t2_count", 32'(o_count), 32'h2);
        check("t2_head", 32'(o_inst), 32'hAAAA);

        // Completing write and ack on the same edge, then wrap across further cycles.
        step(0, 8'h00, 0, 1);
        step(1, 8'hAA, 0, 0); step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0); step(1, 8'hBB, 1, 0);
        check("t3_count", 32'(o_count), 32'h1);
        check("t3_inst", 32'(o_inst), 32'hBBBB);
        step(1, 8'h11, 0, 0); step(1, 8'h22, 1, 0);
        check("t3_wrap_inst", 32'(o_inst), 32'h1122);
        step(0, 8'h00, 1, 0);
        check("t3_empty_valid", 32'(o_inst_valid), 32'h0);

        // Flush beats a simultaneous store.
        step(1, 8'h56, 0, 0);
        step(1, 8'h78, 0, 1);
        check("t4_count", 32'(o_count), 32'h0);
        check("t4_index", 32'(o_byte_index), 32'h0);
        check("t4_valid", 32'(o_inst_valid), 32'h0);
        check("t4_inst", 32'(o_inst), 32'h0);
        step(1, 8'h9A, 0, 0); step(1, 8'hBC, 0, 0);
        check("t4_next", 32'(o_inst), 32'h9ABC);

        // Asynchronous reset mid-instruction drops the partial byte.
        step(1, 8'h11, 0, 0);
        async_reset();
        step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0);
        check("t5_after_rst", 32'(o_inst), 32'h2233);
        step(0, 8'h00, 1, 0);

        // Same-cycle ack of a just-completed instruction on an empty queue.
        step(1, 8'hDE, 0, 0);
        drive(1, 8'hAD, 1, 0);
        compare("t6");
        check("t6_valid_same", 32'(o_inst_valid), 32'(BYPASS));
        check("t6_inst_same", 32'(o_inst), BYPASS ? 32'hDEAD : 32'h0);
        clock_update();
        check("t6_count_after", 32'(o_count), BYPASS ? 32'h0 : 32'h1);
        step(0, 8'h00, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
